placar_pontuacao: RTL
=====================

PLACAR_PONTUACAO -- requirements
Module: placar_pontuacao

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: cycles a synchronized button level must stay stable before it is accepted.
REQ-002 The block SHALL have parameter BUZZER_CYCLES, default 25000000: buzzer pulse length in cycles.
REQ-003 clock  in  1  single system clock; all state on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cBotoes  in  3  raw score buttons, active-high, asynchronous; bit0=1 pt, bit1=2 pts, bit2=3 pts.
REQ-006 chaveNP  in  1  operation select, asynchronous; 0=add, 1=subtract.
REQ-007 chaveTime  in  1  team select, asynchronous; 0=team A, 1=team B.
REQ-008 placarA  out  7  team A score, binary, range 0..99.
REQ-009 placarB  out  7  team B score, binary, range 0..99.
REQ-010 led  out  1  high while the last press was a rejected subtraction.
REQ-011 buzzer  out  1  high for BUZZER_CYCLES after a team reaches 99.
REQ-012 ocupado  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Each cBotoes bit, chaveNP and chaveTime SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Each synchronized button SHALL be debounced: the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a stable differing input; the counter restarts on any bounce.
REQ-015 A press SHALL be a 0->1 transition of a debounced button level.
REQ-016 If press events coincide in one cycle, only the highest-index button SHALL count (3 > 2 > 1 pts).
REQ-017 FSM states SHALL be IDLE, APLICA, ESPERA_SOLTAR.
REQ-018 IDLE->APLICA on a press: latch pts (1..3), synchronized chaveNP and chaveTime.
REQ-019 APLICA->ESPERA_SOLTAR unconditionally after one cycle; the selected score updates on that edge, 2 cycles after the debounced rise.
REQ-020 ESPERA_SOLTAR->IDLE when all three debounced levels are 0; presses in ESPERA_SOLTAR SHALL be ignored.
REQ-021 Add: new = score+pts; if the sum exceeds 99, the score saturates at 99; led clears.
REQ-022 Subtract with pts <= score: new = score-pts; led clears.
REQ-023 Subtract with pts > score: score unchanged, led set, held until the next accepted operation or reset.
REQ-024 Internal sum SHALL be 8 bits wide, so 99+3 is never truncated before saturation.
REQ-025 Any add in APLICA whose result is 99 SHALL load the buzzer counter with BUZZER_CYCLES, including adds already at 99; a reload SHALL restart the pulse.
REQ-026 buzzer SHALL be high while the buzzer counter is nonzero.
REQ-027 Changes of chaveNP or chaveTime after the IDLE latch SHALL NOT affect the operation in progress.
REQ-028 The non-selected team score SHALL never change.

Reset
REQ-029 reset_n low SHALL immediately force: placarA=0, placarB=0, led=0, buzzer=0, ocupado=0, FSM=IDLE, debounce counters=0, debounced levels=0, synchronizers=0, buzzer counter=0.
REQ-030 Reset asserted mid-operation (APLICA or ESPERA_SOLTAR) SHALL abort the operation with no score update.
REQ-031 After reset release, a button already held SHALL register as a press once debounced.

Structure
REQ-032 Shared package placar_pkg SHALL hold MAX_PONTOS=99, the FSM state enum, and the pts width constant.
REQ-033 Debouncing SHALL be a sub-module debounce_botao (synchronizer, counter, stable-level output), instantiated three times.
REQ-034 Team select and chaveNP synchronizers SHALL live in the top module.

Verification
REQ-035 Reset, placarA=0; tap bit2, chaveNP=0, chaveTime=0 -> placarA=3 two cycles after debounce, ocupado pulses, placarB=0.
REQ-036 placarB=98, add bit1 -> placarB=99, buzzer high exactly BUZZER_CYCLES; second add 1 -> placarB stays 99, buzzer restarts.
REQ-037 placarA=1, subtract bit2 -> placarA=1, led=1; then subtract bit0 -> placarA=0, led=0.
REQ-038 Bounce on bit0 shorter than DEBOUNCE_CYCLES -> no score change; simultaneous bit0+bit2 rise -> +3 only; holding bit2 2x DEBOUNCE_CYCLES -> single +3.
REQ-039 Toggle chaveTime one cycle after the IDLE latch -> originally selected team updated.
REQ-040 reset_n low during APLICA -> all outputs 0 asynchronously, no update after release.

Source files
------------

// File: rtl/placar_pkg.sv
// placar_pkg: shared constants, FSM state type and button priority helper
// for the scoreboard.
package placar_pkg;

    localparam logic [6:0] MAX_PONTOS = 7'd99;
    localparam int PTS_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        APLICA,
        ESPERA_SOLTAR
    } estado_t;

    function automatic logic [PTS_W-1:0] ptsPrioridade(input logic [2:0] bordas);
        return bordas[2] ? 2'd3 : bordas[1] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-flop synchronizer followed by a stability counter;
// nivel follows the synchronized input only after it has differed for DEBOUNCE_CYCLES cycles.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic nivel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sincr;
    logic [CNT_W-1:0] contador;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sincr    <= '0;
            contador <= '0;
            nivel    <= 1'b0;
        end else begin
            sincr <= {sincr[0], botao};
            // any cycle agreeing with the current level is a bounce and restarts the count
            if (sincr[1] != nivel) begin
                if (contador == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    nivel    <= sincr[1];
                    contador <= '0;
                end else begin
                    contador <= contador + 1'b1;
                end
            end else begin
                contador <= '0;
            end
        end
    end

endmodule

// File: rtl/placar_pontuacao.sv
// placar_pontuacao: two-team 0..99 scoreboard driven by three debounced
// point buttons, with add/subtract select, rejected-subtract LED and 99-point buzzer.
module placar_pontuacao
    import placar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BUZZER_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] cBotoes,
    input  logic       chaveNP,
    input  logic       chaveTime,
    output logic [6:0] placarA,
    output logic [6:0] placarB,
    output logic       led,
    output logic       buzzer,
    output logic       ocupado
);

    localparam int BUZ_W = $clog2(BUZZER_CYCLES + 1);

    logic [2:0]       nivel, nivelAnt, borda;
    logic [1:0]       npSync, timeSync;
    estado_t          estado, proxEstado;
    logic [PTS_W-1:0] ptsQ;
    logic             npQ, timeQ;
    logic [BUZ_W-1:0] buzCnt;
    logic [6:0]       alvo, novo;
    logic [7:0]       soma;
    logic             rejeita;

    for (genvar i = 0; i < 3; i++) begin : g_deb
        debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock  (clock),
            .reset_n(reset_n),
            .botao  (cBotoes[i]),
            .nivel  (nivel[i])
        );
    end

    assign borda   = nivel & ~nivelAnt;
    assign alvo    = timeQ ? placarB : placarA;
    // 8-bit sum so 99+3 is seen as 102 before saturation
    assign soma    = {1'b0, alvo} + {6'b0, ptsQ};
    assign rejeita = npQ && ({5'b0, ptsQ} > alvo);
    assign novo    = npQ ? alvo - {5'b0, ptsQ}
                         : (soma > {1'b0, MAX_PONTOS}) ? MAX_PONTOS : soma[6:0];
    assign buzzer  = buzCnt != '0;
    assign ocupado = estado != IDLE;

    always_comb begin
        proxEstado = estado;
        case (estado)
            IDLE:          proxEstado = |borda ? APLICA : IDLE;
            APLICA:        proxEstado = ESPERA_SOLTAR;
            ESPERA_SOLTAR: proxEstado = (nivel == 3'b000) ? IDLE : ESPERA_SOLTAR;
            default:       proxEstado = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= IDLE;
            nivelAnt <= '0;
            npSync   <= '0;
            timeSync <= '0;
            ptsQ     <= '0;
            npQ      <= 1'b0;
            timeQ    <= 1'b0;
            placarA  <= '0;
            placarB  <= '0;
            led      <= 1'b0;
            buzCnt   <= '0;
        end else begin
            estado   <= proxEstado;
            nivelAnt <= nivel;
            npSync   <= {npSync[0], chaveNP};
            timeSync <= {timeSync[0], chaveTime};
            if (estado == IDLE && |borda) begin
                ptsQ  <= ptsPrioridade(borda);
                npQ   <= npSync[1];
                timeQ <= timeSync[1];
            end
            if (estado == APLICA) begin
                led <= rejeita;
                if (!rejeita && timeQ) placarB <= novo;
                if (!rejeita && !timeQ) placarA <= novo;
            end
            if (estado == APLICA && !npQ && novo == MAX_PONTOS)
                buzCnt <= BUZ_W'(BUZZER_CYCLES);
            else if (buzCnt != '0)
                buzCnt <= buzCnt - 1'b1;
        end
    end

endmodule
